// File: rtl/bcd_to_b16.sv
// bcd_to_b16: sequential five-digit BCD to 16-bit binary converter.
// One digit per clock (multiply-by-10 and add), start/busy/done handshake,
// with overflow and illegal-digit reporting. A blank code is accepted only
// as leading-zero suppression.
module bcd_to_b16 #(
    parameter logic [3:0] BLANK    = 4'b1111,
    parameter bit         SATURATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        start,
    input  logic [3:0]  D5,
    input  logic [3:0]  D4,
    input  logic [3:0]  D3,
    input  logic [3:0]  D2,
    input  logic [3:0]  D1,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        overflow,
    output logic        bad_digit
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t      r_state, w_state_next;
    // Latched digits, most significant nibble is the digit being processed;
    // the register shifts left one nibble per step.
    logic [19:0] r_digits, w_digits_next;
    logic [2:0]  r_idx, w_idx_next;
    logic [16:0] r_acc, w_acc_next;
    logic        r_seen, w_seen_next;
    logic        r_err, w_err_next;
    logic        r_busy, w_busy_next;
    logic        r_done, w_done_next;
    logic [15:0] r_result, w_result_next;
    logic        r_overflow, w_overflow_next;
    logic        r_bad, w_bad_next;

    logic [3:0]  w_digit;
    logic [16:0] w_acc_step;
    logic        w_seen_step;
    logic        w_err_step;

    assign w_digit = r_digits[19:16];

    // One conversion step on the current digit: accumulate, skip leading blank, or flag error.
    always_comb begin
        w_acc_step  = r_acc;
        w_seen_step = r_seen;
        w_err_step  = r_err;
        if (w_digit <= 4'd9) begin
            w_acc_step  = (r_acc << 3) + (r_acc << 1) + {13'd0, w_digit};
            w_seen_step = 1'b1;
        end else if ((w_digit == BLANK) && !r_seen) begin
            w_acc_step = r_acc;
        end else begin
            w_err_step = 1'b1;
        end
    end

    // Next-state and datapath update for the IDLE/CONV controller.
    always_comb begin
        w_state_next    = r_state;
        w_digits_next   = r_digits;
        w_idx_next      = r_idx;
        w_acc_next      = r_acc;
        w_seen_next     = r_seen;
        w_err_next      = r_err;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_result_next   = r_result;
        w_overflow_next = r_overflow;
        w_bad_next      = r_bad;
        case (r_state)
            ST_IDLE: begin
                if (enable && start) begin
                    w_state_next  = ST_CONV;
                    w_digits_next = {D5, D4, D3, D2, D1};
                    w_acc_next    = 17'd0;
                    w_idx_next    = 3'd4;
                    w_seen_next   = 1'b0;
                    w_err_next    = 1'b0;
                    w_busy_next   = 1'b1;
                end
            end
            ST_CONV: begin
                if (!enable) begin
                    // Abort: outputs keep the last completed conversion.
                    w_state_next = ST_IDLE;
                    w_busy_next  = 1'b0;
                end else begin
                    w_digits_next = {r_digits[15:0], 4'h0};
                    w_acc_next    = w_acc_step;
                    w_seen_next   = w_seen_step;
                    w_err_next    = w_err_step;
                    if (r_idx == 3'd0) begin
                        w_state_next = ST_IDLE;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                        // An illegal digit outranks overflow.
                        if (w_err_step) begin
                            w_result_next   = 16'h0000;
                            w_bad_next      = 1'b1;
                            w_overflow_next = 1'b0;
                        end else if (w_acc_step[16]) begin
                            w_result_next   = SATURATE ? 16'hFFFF : w_acc_step[15:0];
                            w_bad_next      = 1'b0;
                            w_overflow_next = 1'b1;
                        end else begin
                            w_result_next   = w_acc_step[15:0];
                            w_bad_next      = 1'b0;
                            w_overflow_next = 1'b0;
                        end
                    end else begin
                        w_idx_next = r_idx - 3'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_digits   <= 20'd0;
            r_idx      <= 3'd0;
            r_acc      <= 17'd0;
            r_seen     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= 16'd0;
            r_overflow <= 1'b0;
            r_bad      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_digits   <= w_digits_next;
            r_idx      <= w_idx_next;
            r_acc      <= w_acc_next;
            r_seen     <= w_seen_next;
            r_err      <= w_err_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_result   <= w_result_next;
            r_overflow <= w_overflow_next;
            r_bad      <= w_bad_next;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign bad_digit = r_bad;

endmodule

// File: tb/tb_bcd_to_b16.sv
// tb_bcd_to_b16: scoreboard bench for bcd_to_b16, run on a saturating and a
// wrapping instance sharing the same stimulus.
module tb_bcd_to_b16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  d5 = 4'd0, d4 = 4'd0, d3 = 4'd0, d2 = 4'd0, d1 = 4'd0;

    logic        busy_a, done_a, ovf_a, bad_a;
    logic [15:0] result_a;
    logic        busy_b, done_b, ovf_b, bad_b;
    logic [15:0] result_b;

    bcd_to_b16 #(.BLANK(4'b1111), .SATURATE(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
        .D5(d5), .D4(d4), .D3(d3), .D2(d2), .D1(d1),
        .busy(busy_a), .done(done_a), .result(result_a),
        .overflow(ovf_a), .bad_digit(bad_a)
    );

    bcd_to_b16 #(.BLANK(4'b1111), .SATURATE(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
        .D5(d5), .D4(d4), .D3(d3), .D2(d2), .D1(d1),
        .busy(busy_b), .done(done_b), .result(result_b),
        .overflow(ovf_b), .bad_digit(bad_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic [17:0] exp;   // {bad, ovf, result}
        int          cyc;   // cycle in which done must be visible
        logic [19:0] dv;
    } sb_t;

    sb_t qa[$];
    sb_t qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: decimal value from the digit rules, then flag selection.
    function automatic logic [17:0] ref_conv(input logic [19:0] dv, input bit sat);
        int          val;
        bit          seen;
        bit          err;
        logic [3:0]  d;
        logic [31:0] v32;
        val  = 0;
        seen = 0;
        err  = 0;
        for (int i = 4; i >= 0; i--) begin
            d = dv[i*4 +: 4];
            if (d <= 4'd9) begin
                val  = val * 10 + int'(d);
                seen = 1;
            end else if (!(d == 4'hF && !seen)) begin
                err = 1;
            end
        end
        v32 = 32'(val);
        if (err) return {1'b1, 1'b0, 16'h0000};
        if (val > 65535) return {1'b0, 1'b1, (sat ? 16'hFFFF : v32[15:0])};
        return {2'b00, v32[15:0]};
    endfunction

    function automatic logic [19:0] rand_dv();
        logic [19:0] dv;
        int          r;
        for (int i = 0; i < 5; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 12)      dv[i*4 +: 4] = 4'(r % 10);
            else if (r < 16) dv[i*4 +: 4] = 4'hF;
            else             dv[i*4 +: 4] = 4'($urandom_range(10, 14));
        end
        return dv;
    endfunction

    task automatic set_digits(input logic [19:0] dv);
        {d5, d4, d3, d2, d1} = dv;
    endtask

    task automatic push(input logic [19:0] dv);
        sb_t e;
        e.dv  = dv;
        e.cyc = cyc + 6;
        e.exp = ref_conv(dv, 1'b1);
        qa.push_back(e);
        e.exp = ref_conv(dv, 1'b0);
        qb.push_back(e);
    endtask

    // Single conversion from IDLE, checking busy over the whole window.
    task automatic convert(input logic [19:0] dv, input bit pulse_busy);
        set_digits(dv);
        start = 1'b1;
        push(dv);
        @(posedge clk); #1;
        start = 1'b0;
        set_digits(20'($urandom));
        for (int k = 1; k <= 5; k++) begin
            chk("busy_a_conv", 32'(busy_a), 32'd1);
            chk("busy_b_conv", 32'(busy_b), 32'd1);
            if (pulse_busy && k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
            @(posedge clk); #1;
        end
        chk("busy_a_end", 32'(busy_a), 32'd0);
        chk("busy_b_end", 32'(busy_b), 32'd0);
    endtask

    // Monitor: pop and compare whenever a done pulse is presented.
    always @(negedge clk) begin
        sb_t e;
        if (done_a === 1'b1) begin
            if (qa.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL unexpected_done_a: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                e = qa.pop_front();
                $display("A digits=%05h result=%04h ovf=%b bad=%b cycle=%0d", e.dv, result_a, ovf_a, bad_a, cyc);
                chk("result_a", 32'(result_a), 32'(e.exp[15:0]));
                chk("ovf_a", 32'(ovf_a), 32'(e.exp[16]));
                chk("bad_a", 32'(bad_a), 32'(e.exp[17]));
                chk("done_cycle_a", 32'(cyc), 32'(e.cyc));
            end
        end
        if (done_b === 1'b1) begin
            if (qb.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL unexpected_done_b: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                e = qb.pop_front();
                $display("B digits=%05h result=%04h ovf=%b bad=%b cycle=%0d", e.dv, result_b, ovf_b, bad_b, cyc);
                chk("result_b", 32'(result_b), 32'(e.exp[15:0]));
                chk("ovf_b", 32'(ovf_b), 32'(e.exp[16]));
                chk("bad_b", 32'(bad_b), 32'(e.exp[17]));
                chk("done_cycle_b", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    logic [19:0] directed [8];
    logic [19:0] dv;

    initial begin
        directed[0] = 20'h65535;
        directed[1] = 20'h65536;
        directed[2] = 20'hFFF42;
        directed[3] = 20'hFFFFF;
        directed[4] = 20'h1F300;
        directed[5] = 20'h9999A;
        directed[6] = 20'h99999;
        directed[7] = 20'h00123;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_result_a", 32'(result_a), 32'd0);
        chk("rst_ovf_a", 32'(ovf_a), 32'd0);
        chk("rst_bad_a", 32'(bad_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        chk("rst_result_b", 32'(result_b), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(posedge clk); #1;

        // start with enable low is ignored
        enable = 1'b0;
        start  = 1'b1;
        set_digits(20'h11111);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        chk("no_start_when_disabled", 32'(busy_a), 32'd0);
        enable = 1'b1;
        @(posedge clk); #1;

        // Directed conversions, last one leaves 123 in the result
        for (int i = 0; i < 8; i++) convert(directed[i], (i % 2) == 1);
        @(posedge clk); #1;

        // enable dropped two cycles after start: abort, result holds
        set_digits(20'h98765);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy_a", 32'(busy_a), 32'd0);
        enable = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_hold_a", 32'(result_a), 32'd123);
        chk("abort_hold_b", 32'(result_b), 32'd123);
        chk("abort_ovf_a", 32'(ovf_a), 32'd0);

        // reset mid-conversion
        set_digits(20'h55555);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_result_a", 32'(result_a), 32'd0);
        chk("midrst_busy_a", 32'(busy_a), 32'd0);
        chk("midrst_result_b", 32'(result_b), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_hold_a", 32'(result_a), 32'd0);

        // Next start converts normally
        convert(20'h04321, 1'b0);

        // Back-to-back with start held; digits change after each accept
        start = 1'b1;
        for (int n = 0; n < 6; n++) begin
            dv = rand_dv();
            set_digits(dv);
            push(dv);
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                set_digits(20'($urandom));
            end
        end
        start = 1'b0;
        @(posedge clk); #1;

        // Randomised conversions, some with start pulses during busy
        for (int n = 0; n < 30; n++) begin
            convert(rand_dv(), $urandom_range(0, 1) == 1);
        end

        repeat (10) @(posedge clk);
        #1;
        chk("drained_a", 32'(qa.size()), 32'd0);
        chk("drained_b", 32'(qb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_to_b16.md
Name: bcd_to_b16

Overview:
- Sequential converter from five BCD display digits (D5 = most significant ... D1 = least significant) back to a 16-bit unsigned binary value.
- It is the inverse of the team's binary-to-BCD display path. The digit code 4'b1111 means "blank".
- It sits between digit-entry/display logic and the datapath that consumes binary operands.
- Conversion is multiply-by-10 / add, one digit per clock, under a start/busy/done handshake, with overflow and bad-digit reporting.

Parameters:
- BLANK, 4'b1111, digit code treated as a blank (leading-zero suppression code).
- SATURATE, 1, on overflow: 1 = result forced to 16'hFFFF; 0 = result is the low 16 bits of the accumulator.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  synchronous reset, active-low
- enable  input  1  1 = block operates; 0 = aborts any conversion and returns to IDLE
- start  input  1  request conversion; sampled only in IDLE
- D5  input  4  digit 4 (ten-thousands)
- D4  input  4  digit 3 (thousands)
- D3  input  4  digit 2 (hundreds)
- D2  input  4  digit 1 (tens)
- D1  input  4  digit 0 (units)
- busy  output  1  conversion in progress
- done  output  1  single-cycle pulse: result and flags updated
- result  output  16  converted binary value, held until next done
- overflow  output  1  last conversion exceeded 65535
- bad_digit  output  1  last conversion saw an illegal digit

Behaviour:
- Reset: rst_n = 0 at a clk edge forces state IDLE, busy = 0, done = 0, result = 0, overflow = 0, bad_digit = 0, acc = 0. Reset has priority over every other input, including mid-conversion.
- States: IDLE, CONV. An internal digit index runs 4 down to 0. The accumulator is 17 bits, which covers the 99999 maximum.
- IDLE:
  - At an edge with enable = 1 and start = 1: latch D5..D1 into an internal digit register, set acc = 0, index = 4, seen_nonblank = 0, err = 0, busy = 1, go to CONV.
  - Otherwise remain in IDLE.
  - start with enable = 0 is ignored.
- CONV: each edge takes d = digit[index].
  - d <= 9: acc = acc*10 + d; seen_nonblank = 1.
  - d == BLANK and seen_nonblank == 0: leading blank, acc unchanged (blank counts as 0).
  - d == BLANK after a non-blank digit, or d in 10..14: err = 1; acc update is don't-care.
  - index decrements.
- Final digit (the edge processing index 0), computed from the final accumulator:
  - err: result = 0, bad_digit = 1, overflow = 0 (error outranks overflow).
  - else acc > 65535: overflow = 1, bad_digit = 0, result = 16'hFFFF if SATURATE else acc[15:0].
  - else: result = acc[15:0], both flags 0.
  - On the same edge: done = 1 for exactly one cycle, busy = 0, state returns to IDLE.
- Latency: start sampled at edge E0; digits processed on E1..E5; done is high during the cycle after E5.
  - busy is high from after E0 through the E5 edge.
  - A start held high during the done cycle is accepted at E6. Back-to-back throughput is one conversion per 6 clocks.
- Start is ignored while busy. Digit inputs may change freely after E0, because they are latched.
- enable = 0 at any edge while in CONV: return to IDLE, busy = 0, no done. result and flags keep their previous values.
- All-blank input converts to 0 with no flags.
- result, overflow and bad_digit change only at a done edge or at reset.

Test Plan:
- Reset, then start with D5..D1 = 6,5,5,3,5 -> done exactly 6 cycles after the start edge; result = 16'hFFFF; overflow = 0; bad_digit = 0; busy high for 5 cycles.
- D5..D1 = 6,5,5,3,6 with SATURATE = 1 -> result 16'hFFFF, overflow = 1. Same digits with SATURATE = 0 -> result 16'h0000, overflow = 1.
- Leading blanks F,F,F,4,2 -> result 42 (16'h002A), no flags. All-blank F,F,F,F,F -> result 0, no flags.
- Illegal digits:
  - Embedded blank 1,F,3,0,0 -> bad_digit = 1, result = 0.
  - Digit 4'hA in D1 with 9,9,9,9,A -> bad_digit = 1, overflow = 0.
  - Next legal conversion clears both flags.
- Mid-operation disruption (result holds 123 from a prior conversion of 0,0,1,2,3):
  - enable dropped 2 cycles after start -> no done pulse, result still 123, busy = 0.
  - rst_n pulled low mid-conversion -> result 0, busy 0, no done.
  - Next start converts normally.
- Back-to-back handshake:
  - start held high continuously with digits changing after each accept -> each conversion uses the digits latched at its start edge; done pulses every 6 cycles.
  - start pulses during busy are ignored.
